// File: rtl/k_fifo2_ctrl.sv
// Handshake sequencer for a 2-entry dual-port RAM: pointer pair with wrap bit, full/empty/count.
// Optional sticky overflow/underflow flags when K_FIFO2_ERR_FLAG_EN is defined.
module k_fifo2_ctrl #(
    parameter int data_size = 8,
    parameter int depth     = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [data_size-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [data_size-1:0] out_data,
    output logic [data_size-1:0] ram_d,
    output logic                 ram_wen,
    output logic                 ram_waddr,
    output logic                 ram_raddr,
    input  logic [data_size-1:0] ram_q,
    output logic                 full,
    output logic                 empty,
    output logic [1:0]           count
`ifdef K_FIFO2_ERR_FLAG_EN
    ,
    output logic                 ovf,
    output logic                 unf
`endif
);

    generate
        if (depth != 2) begin : g_bad_depth
            $error("k_fifo2_ctrl: depth must be 2");
        end
    endgenerate

    // Bit 0 addresses the RAM, bit 1 distinguishes full from empty when addresses match.
    logic [1:0] wptr_reg, wptr_next;
    logic [1:0] rptr_reg, rptr_next;
    logic       push;
    logic       pop;

    always_comb begin
        empty     = (wptr_reg == rptr_reg);
        full      = (wptr_reg[0] == rptr_reg[0]) && (wptr_reg[1] != rptr_reg[1]);
        count     = wptr_reg - rptr_reg;
        in_ready  = !full;
        out_valid = !empty;
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
        wptr_next = wptr_reg + {1'b0, push};
        rptr_next = rptr_reg + {1'b0, pop};
    end

    // Mask the write strobe during reset so a held in_valid cannot corrupt RAM.
    assign ram_wen   = push && !rst;
    assign ram_waddr = wptr_reg[0];
    assign ram_raddr = rptr_reg[0];
    assign ram_d     = in_data;
    assign out_data  = ram_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_reg <= 2'd0;
            rptr_reg <= 2'd0;
        end else begin
            wptr_reg <= wptr_next;
            rptr_reg <= rptr_next;
        end
    end

`ifdef K_FIFO2_ERR_FLAG_EN
    logic ovf_reg;
    logic unf_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_reg <= 1'b0;
            unf_reg <= 1'b0;
        end else begin
            if (in_valid && full)
                ovf_reg <= 1'b1;
            if (out_ready && empty)
                unf_reg <= 1'b1;
        end
    end

    assign ovf = ovf_reg;
    assign unf = unf_reg;
`endif

endmodule

// File: tb/tb_k_fifo2_ctrl.sv
// Bench for k_fifo2_ctrl: behavioural RAM plus a queue reference model, directed then random steps.
module tb_k_fifo2_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'd0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic [7:0] ram_d;
    logic       ram_wen;
    logic       ram_waddr;
    logic       ram_raddr;
    logic [7:0] ram_q;
    logic       full;
    logic       empty;
    logic [1:0] count;
`ifdef K_FIFO2_ERR_FLAG_EN
    logic       ovf;
    logic       unf;
`endif

    k_fifo2_ctrl #(.data_size(8), .depth(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .ram_d     (ram_d),
        .ram_wen   (ram_wen),
        .ram_waddr (ram_waddr),
        .ram_raddr (ram_raddr),
        .ram_q     (ram_q),
        .full      (full),
        .empty     (empty),
        .count     (count)
`ifdef K_FIFO2_ERR_FLAG_EN
        ,
        .ovf       (ovf),
        .unf       (unf)
`endif
    );

    always #5 clk = ~clk;

    // Two-entry RAM with combinational read, as the controller expects.
    logic [7:0] ram_mem [2];
    always @(posedge clk) if (ram_wen) ram_mem[ram_waddr] <= ram_d;
    assign ram_q = ram_mem[ram_raddr];

    // Reference model: a FIFO of words plus running push/pop totals since reset.
    logic [7:0] q[$];
    int         npush = 0;
    int         npop  = 0;
    logic       ovf_m = 1'b0;
    logic       unf_m = 1'b0;
    int         total = 0;
    int         bad   = 0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_flags();
`ifdef K_FIFO2_ERR_FLAG_EN
        check("ovf", {7'd0, ovf}, {7'd0, ovf_m});
        check("unf", {7'd0, unf}, {7'd0, unf_m});
`endif
    endtask

    // One clock cycle: drive, check combinational view, clock, update model.
    task automatic step(input logic iv, input logic [7:0] d, input logic ordy);
        logic exp_push, exp_pop;
        int   sz;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        #1;
        sz       = q.size();
        exp_push = iv && (sz < 2);
        exp_pop  = ordy && (sz > 0);
        check("in_ready",  {7'd0, in_ready},  {7'd0, sz < 2});
        check("out_valid", {7'd0, out_valid}, {7'd0, sz > 0});
        check("full",      {7'd0, full},      {7'd0, sz == 2});
        check("empty",     {7'd0, empty},     {7'd0, sz == 0});
        check("count",     {6'd0, count},     8'(sz));
        check("ram_wen",   {7'd0, ram_wen},   {7'd0, exp_push});
        check("ram_waddr", {7'd0, ram_waddr}, 8'(npush % 2));
        check("ram_raddr", {7'd0, ram_raddr}, 8'(npop % 2));
        if (sz > 0)
            check("out_data", out_data, q[0]);
        check_flags();
        $display("txn iv=%0d d=%02h ordy=%0d push=%0d pop=%0d count=%0d out=%02h",
                 iv, d, ordy, exp_push, exp_pop, sz, out_data);
        @(posedge clk);
        if (exp_pop) begin
            void'(q.pop_front());
            npop++;
        end
        if (exp_push) begin
            q.push_back(d);
            npush++;
        end
        if (iv && sz == 2) ovf_m = 1'b1;
        if (ordy && sz == 0) unf_m = 1'b1;
        #1;
    endtask

    task automatic model_reset();
        q.delete();
        npush = 0;
        npop  = 0;
        ovf_m = 1'b0;
        unf_m = 1'b0;
    endtask

    initial begin
        // Power-on reset, checked while held.
        #1 rst = 1'b1;
        #2;
        check("rst_empty",    {7'd0, empty},     8'd1);
        check("rst_full",     {7'd0, full},      8'd0);
        check("rst_count",    {6'd0, count},     8'd0);
        check("rst_in_ready", {7'd0, in_ready},  8'd1);
        check("rst_out_valid",{7'd0, out_valid}, 8'd0);
        check("rst_ram_wen",  {7'd0, ram_wen},   8'd0);
        check_flags();
        @(posedge clk);
        #1 rst = 1'b0;
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);

        // Fill to full, then a rejected third push.
        step(1'b1, 8'hA5, 1'b0);
        step(1'b1, 8'h3C, 1'b0);
        step(1'b1, 8'h77, 1'b0);
        step(1'b1, 8'h77, 1'b1);   // full with push+pop: only the pop happens
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);   // pop while empty
        step(1'b0, 8'h00, 1'b0);

        // Pre-fill one word, then streaming push+pop across pointer wrap.
        step(1'b1, 8'h00, 1'b0);
        for (int i = 1; i <= 6; i++)
            step(1'b1, 8'(i), 1'b1);
        step(1'b0, 8'h00, 1'b0);

        // Reset mid-stream at count=2, with in_valid held high.
        step(1'b1, 8'hE1, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'h55;
        out_ready = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("mid_rst_empty",    {7'd0, empty},    8'd1);
        check("mid_rst_count",    {6'd0, count},    8'd0);
        check("mid_rst_in_ready", {7'd0, in_ready}, 8'd1);
        check("mid_rst_ram_wen",  {7'd0, ram_wen},  8'd0);
        model_reset();
        check_flags();
        in_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        step(1'b1, 8'h11, 1'b0);
        step(1'b0, 8'h00, 1'b1);

        // Random traffic against the model.
        for (int i = 0; i < 150; i++)
            step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
